// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//
// Execute-stage operand select and D/E pipeline register.
// Both ALU operands come through a forwarding network with NFWD sources.
// Operand B can then be replaced by the immediate. The resolved operands and
// the store data are registered with stall, flush and valid control. A
// saturating counter records how many cycles a valid instruction was held by
// a stall, for performance debug.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   stall, flush    hold the registers / insert a bubble (flush wins)
//   in_valid        the incoming D-stage instruction is real
//   rs_data/rt_data register-file read values for operands A and B
//   ext_imm         already-extended immediate
//   alu_src         1: op_b takes ext_imm, 0: op_b takes the forwarded rt
//   fwd_a_sel/_b    forward selects (0 = register file, k = source k)
//   fwd_data        packed sources, source k in [k*WIDTH-1:(k-1)*WIDTH]
//   out_valid, op_a, op_b, store_data   registered E-stage outputs
//   stall_cnt       saturating count of stalled cycles holding a valid instr
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int NFWD  = 2,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      rs_data,
  input  logic [WIDTH-1:0]      rt_data,
  input  logic [WIDTH-1:0]      ext_imm,
  input  logic                  alu_src,
  input  logic [SEL_W-1:0]      fwd_a_sel,
  input  logic [SEL_W-1:0]      fwd_b_sel,
  input  logic [NFWD*WIDTH-1:0] fwd_data,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      op_a,
  output logic [WIDTH-1:0]      op_b,
  output logic [WIDTH-1:0]      store_data,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Unpack the forwarding bus into one entry per source (index 0 = source 1).
  logic [WIDTH-1:0] fwd_src [NFWD];

  genvar gi;
  generate
    for (gi = 0; gi < NFWD; gi++) begin : g_unpack
      assign fwd_src[gi] = fwd_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Forward muxes. The register-file value is the default, so selects of 0 or
  // above NFWD fall back to it and the result is never X.
  logic [WIDTH-1:0] a_fwd;
  logic [WIDTH-1:0] rt_fwd;

  always_comb begin
    a_fwd  = rs_data;
    rt_fwd = rt_data;
    for (int k = 1; k <= NFWD; k++) begin
      if (fwd_a_sel == SEL_W'(k)) a_fwd  = fwd_src[k-1];
      if (fwd_b_sel == SEL_W'(k)) rt_fwd = fwd_src[k-1];
    end
  end

  // Pipeline register state.
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Flush has priority over stall. The data fields load even when in_valid
  // is 0; downstream ignores them because out_valid is low.
  always_comb begin
    valid_d = in_valid;
    op_a_d  = a_fwd;
    op_b_d  = alu_src ? ext_imm : rt_fwd;
    sd_d    = rt_fwd;
    if (flush) begin
      valid_d = 1'b0;
      op_a_d  = '0;
      op_b_d  = '0;
      sd_d    = '0;
    end else if (stall) begin
      valid_d = valid_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sd_d    = sd_q;
    end
  end

  // The counter only counts stalls that hold a real instruction. It
  // saturates at all-ones, and only reset clears it (a flush does not).
  always_comb begin
    cnt_d = cnt_q;
    if (stall && !flush && valid_q && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign store_data = sd_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// Testbench for ex_operand_stage.
// Two instances receive the same stimulus: one with the default 16-bit stall
// counter, and one with CNT_W=2 so that counter saturation can be seen.
// Each directed vector is driven on the falling edge, and its hand-computed
// post-edge state is pushed into a queue at the same time. A separate monitor
// wakes 1 ns after each rising edge. It pops one expected entry and compares
// it with the outputs of both instances.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] ext_imm = '0;
  logic        alu_src = 1'b0;
  logic [1:0]  fwd_a_sel = '0;
  logic [1:0]  fwd_b_sel = '0;
  logic [63:0] fwd_data = {32'hBBBB_0000, 32'hAAAA_0000};

  logic        out_valid, out_valid_s;
  logic [31:0] op_a, op_b, store_data;
  logic [31:0] op_a_s, op_b_s, store_data_s;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt_s;

  always #5 clk = ~clk;

  ex_operand_stage #(.WIDTH(32), .NFWD(2), .SEL_W(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .rs_data(rs_data), .rt_data(rt_data),
    .ext_imm(ext_imm), .alu_src(alu_src), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .fwd_data(fwd_data), .out_valid(out_valid),
    .op_a(op_a), .op_b(op_b), .store_data(store_data), .stall_cnt(stall_cnt)
  );

  ex_operand_stage #(.WIDTH(32), .NFWD(2), .SEL_W(2), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .rs_data(rs_data), .rt_data(rt_data),
    .ext_imm(ext_imm), .alu_src(alu_src), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .fwd_data(fwd_data), .out_valid(out_valid_s),
    .op_a(op_a_s), .op_b(op_b_s), .store_data(store_data_s),
    .stall_cnt(stall_cnt_s)
  );

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [15:0] c16;
    logic [1:0]  c2;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;

  task automatic chk(input string tname, input string field,
                     input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", tname, field, act, expv);
    end
  endtask

  // Drive one vector on the falling edge and queue its expected post-edge state.
  task automatic vec(input string nm, input logic rst, st, fl, iv,
                     input logic [31:0] rs, rt, imm, input logic alu,
                     input logic [1:0] as, bs,
                     input logic ev, input logic [31:0] ea, eb, esd,
                     input logic [15:0] ec, input logic [1:0] ec2);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = st; flush = fl; in_valid = iv;
    rs_data = rs; rt_data = rt; ext_imm = imm; alu_src = alu;
    fwd_a_sel = as; fwd_b_sel = bs;
    e.name = nm; e.v = ev; e.a = ea; e.b = eb; e.sd = esd; e.c16 = ec; e.c2 = ec2;
    q.push_back(e);
  endtask

  // Monitor: one pop and comparison per rising edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_txn++;
        $display("txn %0d %s: v=%0b a=%08h b=%08h sd=%08h cnt=%0d cnt2=%0d",
                 n_txn, e.name, out_valid, op_a, op_b, store_data, stall_cnt, stall_cnt_s);
        chk(e.name, "out_valid", {31'd0, out_valid}, {31'd0, e.v});
        chk(e.name, "op_a", op_a, e.a);
        chk(e.name, "op_b", op_b, e.b);
        chk(e.name, "store_data", store_data, e.sd);
        chk(e.name, "stall_cnt", {16'd0, stall_cnt}, {16'd0, e.c16});
        chk(e.name, "stall_cnt_sat", {30'd0, stall_cnt_s}, {30'd0, e.c2});
      end
    end
  end

  initial begin
    //   name        rst st fl iv  rs            rt            imm           alu as bs  ev a             b             sd            c16 c2
    vec("reset0",    1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        32'h0,        0,  0);
    vec("reset1",    1, 0, 0, 1, 32'h11,       32'h22,       32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        32'h0,        0,  0);
    vec("load",      0, 0, 0, 1, 32'h11,       32'h22,       32'h0,        0, 0, 0,  1, 32'h11,       32'h22,       32'h22,       0,  0);
    vec("fwd_imm",   0, 0, 0, 1, 32'h1,        32'h2,        32'hFFFF8000, 1, 1, 2,  1, 32'hAAAA0000, 32'hFFFF8000, 32'hBBBB0000, 0,  0);
    vec("sel_oor",   0, 0, 0, 1, 32'h5,        32'h7,        32'h0,        0, 3, 3,  1, 32'h5,        32'h7,        32'h7,        0,  0);
    vec("fwd_swap",  0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 2, 1,  1, 32'hBBBB0000, 32'hAAAA0000, 32'hAAAA0000, 0,  0);
    vec("stall1",    0, 1, 0, 1, 32'h123,      32'h456,      32'h789,      1, 0, 0,  1, 32'hBBBB0000, 32'hAAAA0000, 32'hAAAA0000, 1,  1);
    vec("stall2",    0, 1, 0, 0, 32'h321,      32'h654,      32'h987,      0, 1, 2,  1, 32'hBBBB0000, 32'hAAAA0000, 32'hAAAA0000, 2,  2);
    vec("stall3",    0, 1, 0, 1, 32'hAAA,      32'hBBB,      32'hCCC,      1, 2, 0,  1, 32'hBBBB0000, 32'hAAAA0000, 32'hAAAA0000, 3,  3);
    vec("unstall",   0, 0, 0, 1, 32'h33,       32'h44,       32'h0,        0, 0, 0,  1, 32'h33,       32'h44,       32'h44,       3,  3);
    vec("flush_st",  0, 1, 1, 1, 32'h55,       32'h66,       32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        32'h0,        3,  3);
    vec("stall_inv", 0, 1, 0, 1, 32'h57,       32'h68,       32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        32'h0,        3,  3);
    vec("load_inv",  0, 0, 0, 0, 32'h66,       32'h77,       32'h0,        0, 0, 0,  0, 32'h66,       32'h77,       32'h77,       3,  3);
    vec("load_imm",  0, 0, 0, 1, 32'h1,        32'h2,        32'h9,        1, 0, 0,  1, 32'h1,        32'h9,        32'h2,        3,  3);
    vec("sat1",      0, 1, 0, 0, 32'hF0,       32'hF1,       32'hF2,       0, 1, 1,  1, 32'h1,        32'h9,        32'h2,        4,  3);
    vec("sat2",      0, 1, 0, 0, 32'hF0,       32'hF1,       32'hF2,       0, 1, 1,  1, 32'h1,        32'h9,        32'h2,        5,  3);
    vec("sat3",      0, 1, 0, 1, 32'hF0,       32'hF1,       32'hF2,       0, 1, 1,  1, 32'h1,        32'h9,        32'h2,        6,  3);
    vec("sat4",      0, 1, 0, 1, 32'hF0,       32'hF1,       32'hF2,       0, 1, 1,  1, 32'h1,        32'h9,        32'h2,        7,  3);
    vec("sat5",      0, 1, 0, 1, 32'hF0,       32'hF1,       32'hF2,       0, 1, 1,  1, 32'h1,        32'h9,        32'h2,        8,  3);
    vec("flush",     0, 0, 1, 1, 32'h12,       32'h34,       32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        32'h0,        8,  3);
    vec("reload",    0, 0, 0, 1, 32'h12,       32'h34,       32'h0,        0, 0, 0,  1, 32'h12,       32'h34,       32'h34,       8,  3);
    vec("rst_stall", 1, 1, 0, 1, 32'h99,       32'h98,       32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        32'h0,        0,  0);
    vec("post_rst",  0, 0, 0, 1, 32'hDEAD,     32'hBEEF,     32'h0,        0, 0, 0,  1, 32'hDEAD,     32'hBEEF,     32'hBEEF,     0,  0);

    // Give the monitor a bounded time to drain the queue.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Parametrised successor to the EX-stage ALU operand-B select.
- Resolves both ALU operands through a forwarding network of NFWD sources, then applies the immediate/register select on operand B.
- Registers op_a, op_b and store data into the D/E pipeline boundary, with stall, flush and a valid bit.
- Provides a saturating stall-cycle counter for performance debug.

Parameters:
- WIDTH, 32, datapath width of operands, immediate and forwarded values.
- NFWD, 2, number of forwarding sources (e.g. E/M and M/W results); legal range 1..7.
- SEL_W, 2, width of each forward select; must satisfy 2^SEL_W >= NFWD+1.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold all registered outputs this cycle.
- flush  input  1  insert a bubble this cycle.
- in_valid  input  1  the incoming D-stage instruction is real.
- rs_data  input  WIDTH  register-file read value for operand A.
- rt_data  input  WIDTH  register-file read value for operand B / store data.
- ext_imm  input  WIDTH  already-extended immediate.
- alu_src  input  1  1 selects ext_imm for op_b; 0 selects forwarded rt.
- fwd_a_sel  input  SEL_W  forward select for operand A.
- fwd_b_sel  input  SEL_W  forward select for operand B.
- fwd_data  input  NFWD*WIDTH  forwarding sources; source k (1-based) occupies bits [k*WIDTH-1:(k-1)*WIDTH].
- out_valid  output  1  registered valid of the E-stage instruction.
- op_a  output  WIDTH  registered ALU operand A.
- op_b  output  WIDTH  registered ALU operand B.
- store_data  output  WIDTH  registered forwarded rt, used for stores whatever alu_src is.
- stall_cnt  output  CNT_W  count of cycles stalled while holding a valid instruction.

Behaviour:
- Forward mux (combinational):
  - sel=0 selects the register-file value.
  - sel=k with 1<=k<=NFWD selects source k.
  - sel>NFWD selects the register-file value; never X.
- Next values:
  - a_nxt = fwdA(rs_data).
  - rt_fwd = fwdB(rt_data).
  - b_nxt = alu_src ? ext_imm : rt_fwd.
  - sd_nxt = rt_fwd.
- Register update each rising edge, priority reset > flush > stall > load:
  - reset: out_valid=0, op_a=op_b=store_data=0, stall_cnt=0.
  - flush: out_valid=0, op_a=op_b=store_data=0. Flush wins over a simultaneous stall, so the bubble is inserted even when stalled.
  - stall (no flush): all of out_valid, op_a, op_b, store_data hold their values; inputs are ignored.
  - load: out_valid<=in_valid; op_a<=a_nxt; op_b<=b_nxt; store_data<=sd_nxt.
- Latency: exactly 1 cycle from inputs to outputs on a load cycle. There is no combinational path from inputs to outputs.
- in_valid=0 still loads the data fields (don't-care downstream); only out_valid is cleared.
- stall_cnt:
  - Increments on any edge where stall=1, flush=0, reset=0 and out_valid=1 (pre-edge value).
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset; flush does not clear it.
- Reset asserted mid-stall or mid-flush: reset takes effect on that edge. The first load occurs on the first edge after reset deasserts.
- Widths: no arithmetic on operands; ext_imm is used as given, with no re-extension.

Test Plan:
- Reset then load: reset 2 cycles; then rs_data=0x11, rt_data=0x22, sels=0, alu_src=0, in_valid=1 -> next edge out_valid=1, op_a=0x11, op_b=0x22, store_data=0x22, stall_cnt=0.
- Forwarding and imm select: fwd_data={src2=0xBBBB0000, src1=0xAAAA0000}, fwd_a_sel=1, fwd_b_sel=2, alu_src=1, ext_imm=0xFFFF8000 -> op_a=0xAAAA0000, op_b=0xFFFF8000, store_data=0xBBBB0000.
- Out-of-range select: NFWD=2, fwd_a_sel=3, rs_data=0x5 -> op_a=0x5.
- Stall hold and counter: after a valid load, stall=1 for 3 cycles while changing all inputs -> outputs unchanged for 3 edges, stall_cnt=3; then stall=0 loads the new inputs.
- Flush vs stall: stall=1 and flush=1 on the same cycle with out_valid=1 -> next edge out_valid=0, op_a=op_b=store_data=0, stall_cnt unchanged.
- Saturation and reset priority: CNT_W=2, hold valid and stall 5 cycles -> stall_cnt=3. Then reset=1 together with stall=1 -> stall_cnt=0, out_valid=0.
